ifu_decode_queue: RTL and testbench
===================================

IFU_DECODE_QUEUE -- requirements
Module: ifu_decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of fetch-group entries; legal values are powers of two from 2 to 16.
REQ-002 Port clk_i, input, 1 bit: the single clock.
REQ-003 Port arst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port ifu_valid_i, input, 1 bit: the IFU presents a fetch group.
REQ-005 Port ifu_ready_o, output, 1 bit: the queue accepts the fetch group.
REQ-006 Port ifu_instr_i, input, 128 bits: four 32-bit instructions; slot k occupies bits [32k+31:32k].
REQ-007 Port ifu_grouppc_i, input, XLEN bits: PC of slot 0.
REQ-008 Port ifu_validword_i, input, 4 bits: per-slot valid mask.
REQ-009 Port dec_valid_o, output, 1 bit: the head fetch group is presented to decode.
REQ-010 Port dec_ready_i, input, 1 bit: decode has consumed the whole fetch group.
REQ-011 Ports dec_instr_o (128 bits), dec_grouppc_o (XLEN bits) and dec_validword_o (4 bits), outputs: the head entry fields.
REQ-012 Port flush_i, input, 1 bit: pipeline flush.
REQ-013 Port count_o, output, $clog2(DEPTH)+1 bits: number of occupied entries.
REQ-014 Ports full_o and empty_o, outputs, 1 bit each: occupancy status.

Function
REQ-015 The block SHALL act as a circular FIFO of fetch groups, using write and read pointers of $clog2(DEPTH)+1 bits with a wrap bit.
- full SHALL be: pointer MSBs differ and the low bits are equal.
- empty SHALL be: the pointers are equal.
REQ-016 ifu_ready_o SHALL be !full & !flush_i, so no same-cycle push is possible while the queue is full.
REQ-017 A push SHALL occur on ifu_valid_i & ifu_ready_o & (ifu_validword_i != 4'b0000).
- The entry SHALL be written at the write pointer.
- The write pointer SHALL advance by 1, modulo 2*DEPTH.
REQ-018 A group with validword 4'b0000 SHALL be handshaken (ifu_ready_o asserted under the same rule as REQ-016) and then discarded.
- It SHALL not be stored.
- The pointers and count SHALL not change.
REQ-019 dec_valid_o SHALL be !empty & !flush_i.
- The dec_* data outputs SHALL be driven from the head entry with zero combinational logic beyond the read mux.
REQ-020 A pop SHALL occur on dec_valid_o & dec_ready_i, and SHALL advance the read pointer by 1.
REQ-021 There SHALL be no input-to-output bypass: a group pushed in cycle N first appears on dec_valid_o in cycle N+1.
REQ-022 A simultaneous push and pop (possible only when not full) SHALL leave count_o unchanged and advance both pointers.
REQ-023 When flush_i is high at a clock edge, both pointers SHALL be reset to 0.
- Any push or pop in that cycle SHALL be ignored.
- The queue SHALL be empty in the following cycle.
REQ-024 count_o SHALL equal the write pointer minus the read pointer, modulo 2*DEPTH.
- It SHALL be registered, or derived from registered state only.
REQ-025 dec_* data outputs SHALL hold the last head contents while empty; consumers SHALL ignore them when dec_valid_o is 0.
REQ-026 Entry storage SHALL not be reset; only the pointers are reset.

Reset
REQ-027 When arst_ni is low, both pointers SHALL clear to 0 asynchronously.
REQ-028 In reset: dec_valid_o=0, ifu_ready_o=0, count_o=0, full_o=0, empty_o=1.
- After release, ifu_ready_o=1 from the first cycle in which flush_i is low.
REQ-029 Reset asserted mid-operation SHALL discard all queued groups; no entry SHALL be presented after deassertion.

Structure
REQ-030 The fetch-group struct SHALL be a packed typedef fetch_group_t in the shared prv664 package.
- Fields: instr[127:0], grouppc[XLEN-1:0], validword[3:0].
REQ-031 The DEPTH default and the FETCH_GROUP_WIDTH constant SHALL live in prv664_config.
REQ-032 Pointer and occupancy logic SHALL be a sub-module fifo_ptr_ctrl, parameterised by DEPTH; the storage array stays in ifu_decode_queue.

Verification
REQ-033 Fill: push 4 groups (pc 0x1000, 0x1010, 0x1020, 0x1030; validword 4'b1111) with dec_ready_i=0.
- Required: full_o=1, count_o=4 and ifu_ready_o=0 after the 4th edge.
- A 5th push SHALL be refused.
REQ-034 Drain order: from the full state, hold dec_ready_i=1 for 4 cycles.
- Required: pc 0x1000, 0x1010, 0x1020, 0x1030 in that order, then empty_o=1 and dec_valid_o=0.
REQ-035 Concurrent traffic: with count_o=2, push and pop in the same cycle for 10 cycles.
- Required: count_o stays 2, the pointers wrap past DEPTH, and data order is preserved.
REQ-036 Empty group: push validword 4'b0000 at pc 0x2000.
- Required: ifu_ready_o=1 and count_o unchanged; pc 0x2000 is never output.
REQ-037 Flush: with count_o=3, assert flush_i for 1 cycle together with a push.
- Required: dec_valid_o=0 and ifu_ready_o=0 in the flush cycle; count_o=0 in the next cycle; the pushed group is lost.
REQ-038 Reset: assert arst_ni=0 mid-drain with count_o=2.
- Required: count_o=0, empty_o=1 and dec_valid_o=0 immediately, without waiting for clk_i, and remaining so after release.

Source files
------------

// File: rtl/prv664_config.sv
// Core-wide configuration constants for the prv664 front end.
package prv664_config;

  localparam int XLEN              = 64;
  localparam int IFU_QUEUE_DEPTH   = 4;
  localparam int FETCH_GROUP_WIDTH = 128 + XLEN + 4;

endpackage

// File: rtl/prv664_pkg.sv
// Shared prv664 types passed between pipeline stages.
package prv664_pkg;

  import prv664_config::*;

  typedef struct packed {
    logic [127:0]     instr;
    logic [XLEN-1:0]  grouppc;
    logic [3:0]       validword;
  } fetch_group_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit pointer pair and occupancy/handshake logic for a power-of-two circular FIFO.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       push_req,
  input  logic                       pop_req,
  input  logic                       flush_i,
  output logic                       ready,
  output logic                       valid,
  output logic                       push,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // Reset gates ready directly so the producer sees a refusal during reset.
  assign ready   = arst_ni & ~full & ~flush_i;
  assign valid   = ~empty & ~flush_i;
  assign push    = push_req & ready;
  assign pop     = pop_req & valid;
  assign count   = wr_ptr - rd_ptr;
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ifu_decode_queue.sv
// Fetch-group queue between the IFU and decode; whole groups in, whole groups out.
module ifu_decode_queue
  import prv664_config::*;
  import prv664_pkg::*;
#(
  parameter int DEPTH = IFU_QUEUE_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       ifu_valid_i,
  output logic                       ifu_ready_o,
  input  logic [127:0]               ifu_instr_i,
  input  logic [XLEN-1:0]            ifu_grouppc_i,
  input  logic [3:0]                 ifu_validword_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [127:0]               dec_instr_o,
  output logic [XLEN-1:0]            dec_grouppc_o,
  output logic [3:0]                 dec_validword_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_group_t mem [DEPTH];
  fetch_group_t head;
  logic         push;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    // Empty groups are still handshaken but never reach storage.
    .push_req (ifu_valid_i & (|ifu_validword_i)),
    .pop_req  (dec_ready_i),
    .flush_i  (flush_i),
    .ready    (ifu_ready_o),
    .valid    (dec_valid_o),
    .push     (push),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .count    (count_o),
    .full     (full_o),
    .empty    (empty_o)
  );

  // NOTE: the entry array has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_addr] <= '{instr: ifu_instr_i, grouppc: ifu_grouppc_i, validword: ifu_validword_i};
    end
  end

  assign head            = mem[rd_addr];
  assign dec_instr_o     = head.instr;
  assign dec_grouppc_o   = head.grouppc;
  assign dec_validword_o = head.validword;

endmodule

// File: tb/tb_ifu_decode_queue.sv
// Bench for ifu_decode_queue: directed vector table, corner sequences, randomized model comparison.
module tb_ifu_decode_queue;

  import prv664_config::*;
  import prv664_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic            clk_i = 1'b0;
  logic            arst_ni;
  logic            ifu_valid_i;
  logic            ifu_ready_o;
  logic [127:0]    ifu_instr_i;
  logic [XLEN-1:0] ifu_grouppc_i;
  logic [3:0]      ifu_validword_i;
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [127:0]    dec_instr_o;
  logic [XLEN-1:0] dec_grouppc_o;
  logic [3:0]      dec_validword_o;
  logic            flush_i;
  logic [PW-1:0]   count_o;
  logic            full_o;
  logic            empty_o;

  ifu_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .ifu_valid_i     (ifu_valid_i),
    .ifu_ready_o     (ifu_ready_o),
    .ifu_instr_i     (ifu_instr_i),
    .ifu_grouppc_i   (ifu_grouppc_i),
    .ifu_validword_i (ifu_validword_i),
    .dec_valid_o     (dec_valid_o),
    .dec_ready_i     (dec_ready_i),
    .dec_instr_o     (dec_instr_o),
    .dec_grouppc_o   (dec_grouppc_o),
    .dec_validword_o (dec_validword_o),
    .flush_i         (flush_i),
    .count_o         (count_o),
    .full_o          (full_o),
    .empty_o         (empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk_instr(input logic [63:0] pc);
    logic [31:0] b;
    b = pc[31:0];
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  task automatic drive(input logic v, input logic [3:0] vw, input logic [63:0] pc,
                       input logic dr, input logic fl);
    ifu_valid_i     = v;
    ifu_validword_i = vw;
    ifu_grouppc_i   = pc;
    ifu_instr_i     = mk_instr(pc);
    dec_ready_i     = dr;
    flush_i         = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_occ(input string tag, input int exp_cnt);
    check({tag, ".count"}, 256'(count_o), 256'(exp_cnt));
    check({tag, ".full"},  256'(full_o),  256'(exp_cnt == DEPTH));
    check({tag, ".empty"}, 256'(empty_o), 256'(exp_cnt == 0));
  endtask

  typedef struct {
    logic        valid;
    logic [3:0]  vw;
    logic [63:0] pc;
    logic        dr;
    logic        fl;
    logic        e_ready;
    logic        e_dv;
    logic [63:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t vt[16];
  fetch_group_t model_q[$];

  initial begin
    // Directed table: fill, refused 5th push, drain order, empty group, flush with push.
    vt[0]  = '{1'b1, 4'hF, 64'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,    1};
    vt[1]  = '{1'b1, 4'hF, 64'h1010, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1000, 2};
    vt[2]  = '{1'b1, 4'hF, 64'h1020, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1000, 3};
    vt[3]  = '{1'b1, 4'hF, 64'h1030, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1000, 4};
    vt[4]  = '{1'b1, 4'hF, 64'h1040, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1000, 4};
    vt[5]  = '{1'b0, 4'h0, 64'h0,    1'b1, 1'b0, 1'b0, 1'b1, 64'h1000, 3};
    vt[6]  = '{1'b0, 4'h0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b1, 64'h1010, 2};
    vt[7]  = '{1'b0, 4'h0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b1, 64'h1020, 1};
    vt[8]  = '{1'b0, 4'h0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b1, 64'h1030, 0};
    vt[9]  = '{1'b0, 4'h0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    0};
    vt[10] = '{1'b1, 4'h0, 64'h2000, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    0};
    vt[11] = '{1'b1, 4'h3, 64'h3000, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,    1};
    vt[12] = '{1'b1, 4'h1, 64'h3010, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3000, 2};
    vt[13] = '{1'b1, 4'h8, 64'h3020, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3000, 3};
    vt[14] = '{1'b1, 4'hF, 64'h3030, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,    0};
    vt[15] = '{1'b0, 4'h0, 64'h0,    1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    0};

    // Power-on reset: outputs must be settled without any clock edge.
    arst_ni = 1'b0;
    drive(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
    #2;
    check("rst.ready", 256'(ifu_ready_o), 256'(0));
    check("rst.dec_valid", 256'(dec_valid_o), 256'(0));
    check_occ("rst", 0);
    tick();
    tick();
    arst_ni = 1'b1;
    #1;
    check("rel.ready", 256'(ifu_ready_o), 256'(1));

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].valid, vt[i].vw, vt[i].pc, vt[i].dr, vt[i].fl);
      #1;
      check($sformatf("vec%0d.ready", i), 256'(ifu_ready_o), 256'(vt[i].e_ready));
      check($sformatf("vec%0d.dec_valid", i), 256'(dec_valid_o), 256'(vt[i].e_dv));
      if (vt[i].e_dv) begin
        check($sformatf("vec%0d.pc", i), 256'(dec_grouppc_o), 256'(vt[i].e_pc));
        check($sformatf("vec%0d.instr", i), 256'(dec_instr_o), 256'(mk_instr(vt[i].e_pc)));
      end
      tick();
      check_occ($sformatf("vec%0d", i), vt[i].e_cnt);
    end

    // Concurrent push/pop at count 2; twelve pushes wrap both pointers past 2*DEPTH.
    drive(1'b1, 4'hF, 64'h4000, 1'b0, 1'b0); tick();
    drive(1'b1, 4'hF, 64'h4010, 1'b0, 1'b0); tick();
    check_occ("conc.pre", 2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'hF, 64'h4020 + 64'(16 * i), 1'b1, 1'b0);
      #1;
      check($sformatf("conc%0d.pc", i), 256'(dec_grouppc_o), 256'(64'h4000 + 64'(16 * i)));
      check($sformatf("conc%0d.ready", i), 256'(ifu_ready_o), 256'(1));
      tick();
      check($sformatf("conc%0d.count", i), 256'(count_o), 256'(2));
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
      #1;
      check($sformatf("conc_drain%0d.pc", i), 256'(dec_grouppc_o), 256'(64'h40A0 + 64'(16 * i)));
      tick();
    end
    check_occ("conc.post", 0);

    // Async reset mid-drain with two groups still queued.
    drive(1'b1, 4'hF, 64'h5000, 1'b0, 1'b0); tick();
    drive(1'b1, 4'hF, 64'h5010, 1'b0, 1'b0); tick();
    drive(1'b1, 4'hF, 64'h5020, 1'b0, 1'b0); tick();
    drive(1'b0, 4'h0, 64'h0, 1'b1, 1'b0); tick();
    check("arst.pre_count", 256'(count_o), 256'(2));
    #2;
    arst_ni = 1'b0;
    #1;
    check("arst.dec_valid", 256'(dec_valid_o), 256'(0));
    check("arst.ready", 256'(ifu_ready_o), 256'(0));
    check_occ("arst", 0);
    tick();
    arst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("arst_post%0d.dec_valid", i), 256'(dec_valid_o), 256'(0));
      check_occ($sformatf("arst_post%0d", i), 0);
      tick();
    end

    // Randomized traffic against a queue model.
    model_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fetch_group_t g;
      logic v, dr, fl, e_ready, e_dv, do_push, do_pop;
      g.instr     = {$urandom, $urandom, $urandom, $urandom};
      g.grouppc   = {$urandom, $urandom};
      g.validword = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      v  = ($urandom_range(0, 3) != 0);
      dr = ((cyc / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 59) == 0);
      ifu_valid_i = v; ifu_instr_i = g.instr; ifu_grouppc_i = g.grouppc;
      ifu_validword_i = g.validword; dec_ready_i = dr; flush_i = fl;

      e_ready = (model_q.size() < DEPTH) && !fl;
      e_dv    = (model_q.size() > 0) && !fl;
      #1;
      check("rnd.ready", 256'(ifu_ready_o), 256'(e_ready));
      check("rnd.dec_valid", 256'(dec_valid_o), 256'(e_dv));
      if (e_dv)
        check("rnd.head", 256'({dec_instr_o, dec_grouppc_o, dec_validword_o}), 256'(model_q[0]));

      do_push = v && (g.validword != 4'h0) && e_ready;
      do_pop  = e_dv && dr;
      if (fl) model_q.delete();
      else begin
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(g);
      end
      tick();
      check_occ("rnd", model_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
